// File: rtl/pixel_pattern_gen_if.sv
// Pixel stream bundle between the pattern generator and a framebuffer writer.
// The generator side drives coordinates and pixel data; the consumer side drives requests and pixel_ready.
interface pixel_pattern_gen_if;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  level;
  logic        border_en;
  logic        cont;
  logic        pixel_ready;
  logic [10:0] x;
  logic [10:0] y;
  logic [7:0]  pixel_GS;
  logic        pixel_write;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, mode, level, border_en, cont, pixel_ready,
    output x, y, pixel_GS, pixel_write, busy, frame_done
  );

  modport slave (
    output start, mode, level, border_en, cont, pixel_ready,
    input  x, y, pixel_GS, pixel_write, busy, frame_done
  );
endinterface

// File: rtl/pixel_pattern_gen.sv
// Raster-order test-pattern source: walks (x,y) over a WxH frame and emits a
// grayscale value per pixel, advancing only when the framebuffer accepts.
module pixel_pattern_gen #(
  parameter int H          = 50,
  parameter int W          = 50,
  parameter int CHECK_LOG2 = 3,
  parameter int GSHIFT     = 2,
  parameter int BAR_LOG2   = 3
) (
  input logic                 clock,
  input logic                 reset,
  pixel_pattern_gen_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [10:0] X_LAST = 11'(W - 1);
  localparam logic [10:0] Y_LAST = 11'(H - 1);

  logic [1:0]  state;
  logic [10:0] x_p0;
  logic [10:0] y_p0;
  logic [2:0]  mode_p0;
  logic [7:0]  level_p0;
  logic        border_p0;
  logic        cont_p0;
  logic        accept;
  logic        last_px;
  logic        relatch;

  function automatic logic [7:0] pattern_value(
    input logic [2:0]  m,
    input logic [7:0]  lv,
    input logic [10:0] px,
    input logic [10:0] py
  );
    logic       cx;
    logic       cy;
    logic [7:0] v;
    cx = 1'(px >> CHECK_LOG2);
    cy = 1'(py >> CHECK_LOG2);
    case (m)
      3'd0:    v = lv;
      3'd1:    v = 8'(px << GSHIFT);
      3'd2:    v = 8'(py << GSHIFT);
      3'd3:    v = (cx ^ cy) ? ~lv : lv;
      3'd4:    v = {3'(px >> BAR_LOG2), 5'b0} + lv;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic on_edge(input logic [10:0] px, input logic [10:0] py);
    return (px == 11'd0) || (py == 11'd0) || (px == X_LAST) || (py == Y_LAST);
  endfunction

  assign accept  = (state == RUN) && bus.pixel_ready;
  assign last_px = (x_p0 == X_LAST) && (y_p0 == Y_LAST);
  // A frame begins either from IDLE on start or straight out of DONE when continuous.
  assign relatch = ((state == IDLE) && bus.start) || ((state == DONE) && cont_p0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= RUN;
        RUN:     if (accept && last_px) state <= DONE;
        DONE:    state <= cont_p0 ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_p0   <= 3'd0;
      level_p0  <= 8'd0;
      border_p0 <= 1'b0;
      cont_p0   <= 1'b0;
    end else if (relatch) begin
      mode_p0   <= bus.mode;
      level_p0  <= bus.level;
      border_p0 <= bus.border_en;
      cont_p0   <= bus.cont;
    end
  end

  // Coordinates wrap to the origin on the final accept so they never leave the frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_p0 <= 11'd0;
      y_p0 <= 11'd0;
    end else if (relatch) begin
      x_p0 <= 11'd0;
      y_p0 <= 11'd0;
    end else if (accept) begin
      if (x_p0 == X_LAST) begin
        x_p0 <= 11'd0;
        y_p0 <= (y_p0 == Y_LAST) ? 11'd0 : y_p0 + 11'd1;
      end else begin
        x_p0 <= x_p0 + 11'd1;
      end
    end
  end

  assign bus.x           = x_p0;
  assign bus.y           = y_p0;
  assign bus.pixel_write = (state == RUN);
  assign bus.busy        = (state == RUN);
  assign bus.frame_done  = (state == DONE);
  assign bus.pixel_GS    = (border_p0 && on_edge(x_p0, y_p0)) ? 8'hFF
                         : pattern_value(mode_p0, level_p0, x_p0, y_p0);

endmodule

// File: doc/pixel_pattern_gen.md
PIXEL_PATTERN_GEN -- requirements
Module: pixel_pattern_gen

Interface
REQ-001 Parameter H, default 50: frame height in pixels, 2..2047.
REQ-002 Parameter W, default 50: frame width in pixels, 2..2047.
REQ-003 Parameter CHECK_LOG2, default 3: checkerboard cell edge equals 2^CHECK_LOG2 pixels.
REQ-004 Parameter GSHIFT, default 2: left shift applied to the coordinate in gradient modes.
REQ-005 Parameter BAR_LOG2, default 3: bar width equals 2^BAR_LOG2 pixels in bar mode.
REQ-006 The module has one clock; reset is asynchronous and active-high.
REQ-007 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port start, input, 1: level-sampled frame request.
REQ-010 Port mode, input, 3: pattern select, sampled at frame start.
REQ-011 Port level, input, 8: grayscale base value, sampled at frame start.
REQ-012 Port border_en, input, 1: white-border enable, sampled at frame start.
REQ-013 Port cont, input, 1: continuous-frame enable, sampled at frame start.
REQ-014 Port pixel_ready, input, 1: framebuffer accepts the current pixel.
REQ-015 Port x, output, 11: current column.
REQ-016 Port y, output, 11: current row.
REQ-017 Port pixel_GS, output, 8: grayscale value for (x,y).
REQ-018 Port pixel_write, output, 1: pixel valid.
REQ-019 Port busy, output, 1: high in RUN.
REQ-020 Port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and DONE.
REQ-022 IDLE->RUN SHALL occur when start=1; mode, level, border_en and cont SHALL be latched on that edge, and x and y SHALL be set to 0.
REQ-023 In RUN, pixel_write SHALL be 1; x, y and pixel_GS SHALL remain stable until a cycle with pixel_write=1 and pixel_ready=1 (an accept).
REQ-024 On an accept, x SHALL increment; at x=W-1, x SHALL wrap to 0 and y SHALL increment (raster order, x fastest).
REQ-025 An accept at x=W-1 and y=H-1 SHALL move the FSM to DONE; pixel_write SHALL be 0 in DONE.
REQ-026 In DONE, frame_done SHALL be 1 for exactly one cycle; the next state SHALL be RUN with x=y=0 and inputs re-latched if cont was latched as 1, otherwise IDLE.
REQ-027 start SHALL be ignored while in RUN or DONE; mode/level changes mid-frame SHALL have no effect.
REQ-028 pixel_GS, computed combinationally from x, y and the latched values, SHALL be: mode 0 = level; mode 1 = (x<<GSHIFT)[7:0]; mode 2 = (y<<GSHIFT)[7:0]; mode 3 = level when (x>>CHECK_LOG2)[0] XOR (y>>CHECK_LOG2)[0] = 0, else ~level; mode 4 = {(x>>BAR_LOG2)[2:0], 5'b0} + level (mod 256); modes 5-7 = 8'h00.
REQ-029 When border_en is latched 1, pixel_GS SHALL be 8'hFF whenever x=0, y=0, x=W-1 or y=H-1, overriding the mode value.
REQ-030 busy SHALL equal (state==RUN); x and y SHALL never exceed W-1 and H-1.
REQ-031 pixel_ready held 0 SHALL stall indefinitely with no coordinate change and no lost or duplicated pixel.

Reset
REQ-032 Asserting reset SHALL force IDLE, x=0, y=0, pixel_write=0, busy=0, frame_done=0, all latched inputs to 0, and pixel_GS=8'h00, including mid-frame.
REQ-033 After reset deasserts, no pixel_write SHALL occur until start is sampled 1.

Verification
REQ-034 H=4, W=4, mode=0, level=8'h40, border_en=0, pixel_ready=1, pulse start -> 16 consecutive accepts with (x,y) = (0,0),(1,0)...(3,3), all 8'h40; frame_done high one cycle later; then IDLE.
REQ-035 Same, border_en=1, level=8'h10 -> the 12 edge pixels are 8'hFF; (1,1),(2,1),(1,2),(2,2) are 8'h10.
REQ-036 mode=3, CHECK_LOG2=1, level=8'h0F, W=H=4 -> (0,0)=8'h0F, (2,0)=8'hF0, (2,2)=8'h0F.
REQ-037 pixel_ready toggles pseudo-randomly -> exactly W*H accepts, in strict raster order, with outputs held stable during stalls.
REQ-038 cont=1 -> frame_done pulse is followed by (0,0) valid on the next cycle; two back-to-back frames are correct.
REQ-039 Reset asserted at (2,1) mid-frame -> all outputs immediately at reset values; a new start yields a full frame beginning at (0,0).
